// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller for the MEM stage: drives one req/gnt/rvalid transaction per access,
// aligns and extends load data, and flags misaligned accesses and bus timeouts.
module lsu_bus_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;

  logic [1:0]  size_s;
  logic        misal_s;
  logic        timeout_s;
  logic        req_s, busy_s, misalign_s, err_s, rvld_s;
  logic [31:0] shifted_s;
  logic [31:0] ext_s;

  // Size 11 behaves exactly like a word access everywhere, including the captured copy.
  assign size_s    = (mem_size == 2'b11) ? 2'b10 : mem_size;
  assign misal_s   = ((size_s == 2'b01) && mem_addr[0]) ||
                     ((size_s == 2'b10) && (mem_addr[1:0] != 2'b00));
  // The timeout fires in the TIMEOUT-th waiting cycle after entering GNT/RSP.
  assign timeout_s = (cnt_q == (TIMEOUT - 8'd1));

  assign bus_addr  = {mem_addr[31:2], 2'b00};
  assign bus_we    = mem_we;

  always_comb begin
    case (size_s)
      2'b00:   bus_be = 4'b0001 << mem_addr[1:0];
      2'b01:   bus_be = 4'b0011 << mem_addr[1:0];
      default: bus_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (size_s)
      2'b00:   bus_wdata = {4{mem_wdata[7:0]}};
      2'b01:   bus_wdata = {2{mem_wdata[15:0]}};
      default: bus_wdata = mem_wdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    req_s      = 1'b0;
    busy_s     = 1'b0;
    misalign_s = 1'b0;
    err_s      = 1'b0;
    rvld_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid && misal_s) begin
          misalign_s = 1'b1;
        end else if (mem_valid) begin
          req_s  = 1'b1;
          cnt_d  = 8'd0;
          we_d   = mem_we;
          size_d = size_s;
          uns_d  = mem_unsigned;
          off_d  = mem_addr[1:0];
          if (bus_gnt && mem_we) begin
            state_d = IDLE;
          end else if (bus_gnt) begin
            state_d = RSP;
            busy_s  = 1'b1;
          end else begin
            state_d = GNT;
            busy_s  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GNT: begin
        // A dropped mem_valid while waiting for the grant is a pipeline flush.
        if (!mem_valid || misal_s) begin
          state_d = IDLE;
        end else if (bus_gnt) begin
          req_s = 1'b1;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            state_d = RSP;
            busy_s  = 1'b1;
            cnt_d   = 8'd0;
          end
        end else if (timeout_s) begin
          req_s   = 1'b1;
          err_s   = 1'b1;
          state_d = IDLE;
        end else begin
          req_s  = 1'b1;
          busy_s = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      RSP: begin
        if (bus_rvalid) begin
          rvld_s  = 1'b1;
          state_d = IDLE;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_d = IDLE;
        end else begin
          busy_s = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane select and extension use only the fields captured when the request went out.
  assign shifted_s = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ext_s = uns_q ? {24'h000000, shifted_s[7:0]}  : {{24{shifted_s[7]}},  shifted_s[7:0]};
      2'b01:   ext_s = uns_q ? {16'h0000,   shifted_s[15:0]} : {{16{shifted_s[15]}}, shifted_s[15:0]};
      default: ext_s = shifted_s;
    endcase
  end

  assign bus_req     = req_s & rstn;
  assign busy        = busy_s & rstn;
  assign misalign    = misalign_s & rstn;
  assign bus_err     = err_s & rstn;
  assign rdata_valid = rvld_s & rstn;
  assign rdata       = (rvld_s && rstn) ? ext_s : 32'h0000_0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: per-scenario tasks with inline checks plus a load-data scoreboard.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        busy, rdata_valid, misalign, bus_err;
  logic [31:0] rdata;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  logic [31:0] ld_addr  [6] = '{32'h103, 32'h103, 32'h202, 32'h200, 32'h101, 32'h300};
  logic [1:0]  ld_size  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
  logic        ld_uns   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ld_rdata [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h0000F00D, 32'h00007F00, 32'hCAFEF00D};
  logic [31:0] ld_exp   [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F, 32'hCAFEF00D};
  logic [3:0]  ld_be    [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign), .bus_err(bus_err)
  );

  // Scoreboard: every rdata_valid pulse must match the oldest expected load result.
  always @(negedge clk) begin
    #3;
    if (rdata_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected rdata_valid got rdata=%08h exp no pending load", rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rdata !== sb_exp) $display("FAIL sb_rdata got %08h exp %08h", rdata, sb_exp);
        else pass_cnt++;
      end
    end
  end

  task automatic drive_idle();
    mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_idle();
    mem_valid = 1'b1; mem_size = 2'b00; mem_addr = 32'h12345677;
    @(negedge clk); #1;
    total++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %b exp 0", bus_req); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total++; if ({rdata_valid, misalign, bus_err} !== 3'b000) $display("FAIL rst_pulses got %b exp 000", {rdata_valid, misalign, bus_err}); else pass_cnt++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %08h exp 00000000", rdata); else pass_cnt++;
    total++; if (bus_addr !== 32'h12345674) $display("FAIL rst_bus_addr got %08h exp 12345674", bus_addr); else pass_cnt++;
    total++; if (bus_be !== 4'b1000) $display("FAIL rst_bus_be got %b exp 1000", bus_be); else pass_cnt++;
    @(negedge clk);
    drive_idle();
    rstn = 1'b1;
  endtask

  task automatic test_word_load();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h100;
    exp_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      bus_gnt    = (c == 0);
      bus_rvalid = (c == 2);
      bus_rdata  = (c == 2) ? 32'hDEADBEEF : 32'h0;
      #1;
      total++; if (busy !== (c < 2)) $display("FAIL wl_busy c%0d got %b exp %b", c, busy, (c < 2)); else pass_cnt++;
      total++; if (bus_req !== (c == 0)) $display("FAIL wl_req c%0d got %b exp %b", c, bus_req, (c == 0)); else pass_cnt++;
      total++; if (rdata_valid !== (c == 2)) $display("FAIL wl_rvld c%0d got %b exp %b", c, rdata_valid, (c == 2)); else pass_cnt++;
    end
    total++; if (bus_be !== 4'b1111) $display("FAIL wl_be got %b exp 1111", bus_be); else pass_cnt++;
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (rdata !== 32'h0) $display("FAIL wl_rdata_idle got %08h exp 00000000", rdata); else pass_cnt++;
  endtask

  task automatic test_load_lanes();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_idle();
      mem_valid = 1'b1; mem_size = ld_size[i]; mem_unsigned = ld_uns[i]; mem_addr = ld_addr[i];
      bus_gnt = 1'b1;
      exp_q.push_back(ld_exp[i]);
      #1;
      total++; if (bus_be !== ld_be[i]) $display("FAIL ld%0d_be got %b exp %b", i, bus_be, ld_be[i]); else pass_cnt++;
      total++; if ({bus_req, busy} !== 2'b11) $display("FAIL ld%0d_req_busy got %b exp 11", i, {bus_req, busy}); else pass_cnt++;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = ld_rdata[i];
      mem_addr = 32'h0; mem_size = 2'b10; mem_unsigned = ~ld_uns[i];
      #1;
      total++; if ({bus_req, busy, rdata_valid} !== 3'b001) $display("FAIL ld%0d_done got %b exp 001", i, {bus_req, busy, rdata_valid}); else pass_cnt++;
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_half_store();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b01; mem_addr = 32'h202; mem_wdata = 32'hABCD1234;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus_gnt = (c == 3);
      #1;
      total++; if (busy !== (c < 3)) $display("FAIL hs_busy c%0d got %b exp %b", c, busy, (c < 3)); else pass_cnt++;
      total++; if ({bus_req, bus_we} !== 2'b11) $display("FAIL hs_req_we c%0d got %b exp 11", c, {bus_req, bus_we}); else pass_cnt++;
    end
    total++; if (bus_be !== 4'b1100) $display("FAIL hs_be got %b exp 1100", bus_be); else pass_cnt++;
    total++; if (bus_wdata !== 32'h12341234) $display("FAIL hs_wdata got %08h exp 12341234", bus_wdata); else pass_cnt++;
    total++; if (bus_addr !== 32'h200) $display("FAIL hs_addr got %08h exp 00000200", bus_addr); else pass_cnt++;
    @(negedge clk);
    drive_idle();
    #1;
    total++; if ({bus_req, busy} !== 2'b00) $display("FAIL hs_after got %b exp 00", {bus_req, busy}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h1; mem_wdata = 32'h000000A5; bus_gnt = 1'b1;
    #1;
    total++; if ({bus_req, busy} !== 2'b10) $display("FAIL b2b_byte_req_busy got %b exp 10", {bus_req, busy}); else pass_cnt++;
    total++; if (bus_be !== 4'b0010) $display("FAIL b2b_byte_be got %b exp 0010", bus_be); else pass_cnt++;
    total++; if (bus_wdata !== 32'hA5A5A5A5) $display("FAIL b2b_byte_wdata got %08h exp a5a5a5a5", bus_wdata); else pass_cnt++;
    @(negedge clk);
    mem_size = 2'b10; mem_addr = 32'h10; mem_wdata = 32'hCAFEBABE;
    #1;
    total++; if ({bus_req, busy} !== 2'b10) $display("FAIL b2b_word_req_busy got %b exp 10", {bus_req, busy}); else pass_cnt++;
    total++; if (bus_wdata !== 32'hCAFEBABE) $display("FAIL b2b_word_wdata got %08h exp cafebabe", bus_wdata); else pass_cnt++;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 32'h20;
    exp_q.push_back(32'h5A5A0000);
    #1;
    total++; if ({bus_req, busy} !== 2'b11) $display("FAIL b2b_load_req_busy got %b exp 11", {bus_req, busy}); else pass_cnt++;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5A5A0000;
    #1;
    total++; if ({busy, rdata_valid} !== 2'b01) $display("FAIL b2b_load_done got %b exp 01", {busy, rdata_valid}); else pass_cnt++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h102; bus_gnt = 1'b1;
    #1;
    total++; if ({bus_req, busy, misalign} !== 3'b001) $display("FAIL mis_word got %b exp 001", {bus_req, busy, misalign}); else pass_cnt++;
    @(negedge clk);
    mem_size = 2'b01; mem_addr = 32'h203;
    #1;
    total++; if ({bus_req, busy, misalign} !== 3'b001) $display("FAIL mis_half got %b exp 001", {bus_req, busy, misalign}); else pass_cnt++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++; if ({bus_req, busy, misalign} !== 3'b000) $display("FAIL mis_after got %b exp 000", {bus_req, busy, misalign}); else pass_cnt++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_timeout();
    for (int ld = 0; ld < 2; ld++) begin
      @(negedge clk);
      drive_idle();
      for (int c = 0; c < 7; c++) begin
        if (c > 0) @(negedge clk);
        mem_valid  = (c <= 4);
        mem_we     = (ld == 0);
        mem_size   = 2'b10;
        mem_addr   = 32'h400;
        bus_gnt    = (ld == 1) && (c == 0);
        bus_rvalid = (c == 6);
        bus_rdata  = 32'h77777777;
        #1;
        total++; if (bus_err !== (c == 4)) $display("FAIL to%0d_err c%0d got %b exp %b", ld, c, bus_err, (c == 4)); else pass_cnt++;
        total++; if (busy !== (c < 4)) $display("FAIL to%0d_busy c%0d got %b exp %b", ld, c, busy, (c < 4)); else pass_cnt++;
        total++; if (bus_req !== ((c == 0) || ((ld == 0) && (c <= 4)))) $display("FAIL to%0d_req c%0d got %b exp %b", ld, c, bus_req, ((c == 0) || ((ld == 0) && (c <= 4)))); else pass_cnt++;
        total++; if ({rdata_valid, rdata} !== 33'h0) $display("FAIL to%0d_rdata c%0d got %b/%08h exp 0/00000000", ld, c, rdata_valid, rdata); else pass_cnt++;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h500;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL fl_busy_c0 got %b exp 1", busy); else pass_cnt++;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    total++; if ({bus_req, busy} !== 2'b00) $display("FAIL fl_drop got %b exp 00", {bus_req, busy}); else pass_cnt++;
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h99999999;
    exp_q.push_back(32'h11223344);
    #1;
    total++; if ({bus_req, busy, rdata_valid} !== 3'b110) $display("FAIL fl_new_load got %b exp 110", {bus_req, busy, rdata_valid}); else pass_cnt++;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rdata = 32'h11223344;
    #1;
    total++; if ({busy, rdata_valid} !== 2'b01) $display("FAIL fl_load_done got %b exp 01", {busy, rdata_valid}); else pass_cnt++;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h700; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rstn = 1'b0;
    #1;
    total++; if ({bus_req, busy, rdata_valid, misalign, bus_err} !== 5'b0) $display("FAIL rm_in_reset got %b exp 00000", {bus_req, busy, rdata_valid, misalign, bus_err}); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    mem_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000FFFF;
    #1;
    total++; if ({busy, rdata_valid} !== 2'b00) $display("FAIL rm_late_rvalid got %b exp 00", {busy, rdata_valid}); else pass_cnt++;
    total++; if (rdata !== 32'h0) $display("FAIL rm_rdata got %08h exp 00000000", rdata); else pass_cnt++;
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_load_lanes();
    test_half_store();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid();
    @(negedge clk); #4;
    total++; if (exp_q.size() != 0) $display("FAIL sb_pending got %0d exp 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
